// File: rtl/mips_muldiv_unit.sv
// Execute-stage HI/LO multiply/divide unit: fixed-latency multiply, radix-2 restoring divide.
// Define MULDIV_MADD_EN to build MADD/MADDU/MSUB/MSUBU; otherwise those opcodes decode as NONE.
module mips_muldiv_unit #(
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        EX_Stall,
   input  logic        EX_Flush,
   input  logic [3:0]  EX_MulDivOp,
   input  logic [31:0] EX_OpA,
   input  logic [31:0] EX_OpB,
   output logic        MD_Busy,
   output logic        MD_Stall,
   output logic [31:0] MD_Hi,
   output logic [31:0] MD_Lo
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;   // product in MUL, {remainder, quotient} in DIV/FIX
   logic [31:0] dvs_q, dvs_d;
   logic        qneg_q, qneg_d, rneg_q, rneg_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MULDIV_MADD_EN
   logic [1:0]  mode_q, mode_d; // 0 write, 1 accumulate, 2 subtract
   logic [1:0]  op_mode;
`endif

   logic        op_mul, op_div, op_mt, op_any, op_signed, accept;
   logic [63:0] ext_a, ext_b, product;
   logic [31:0] abs_a, abs_b;
   logic        div_zero;
   logic [32:0] rem_sh;
   logic [33:0] trial;

   always_comb begin
      op_mul    = 1'b0;
      op_div    = 1'b0;
      op_signed = 1'b0;
`ifdef MULDIV_MADD_EN
      op_mode   = 2'd0;
`endif
      case (EX_MulDivOp)
         4'd1: begin op_mul = 1'b1; op_signed = 1'b1; end
         4'd2: op_mul = 1'b1;
         4'd3: begin op_div = 1'b1; op_signed = 1'b1; end
         4'd4: op_div = 1'b1;
`ifdef MULDIV_MADD_EN
         4'd5: begin op_mul = 1'b1; op_signed = 1'b1; op_mode = 2'd1; end
         4'd6: begin op_mul = 1'b1; op_mode = 2'd1; end
         4'd7: begin op_mul = 1'b1; op_signed = 1'b1; op_mode = 2'd2; end
         4'd8: begin op_mul = 1'b1; op_mode = 2'd2; end
`endif
         default: ;
      endcase
      op_mt  = (EX_MulDivOp == 4'd9) || (EX_MulDivOp == 4'd10);
      op_any = op_mul || op_div || op_mt || (EX_MulDivOp == 4'd11) || (EX_MulDivOp == 4'd12);
      accept = (state_q == StIdle) && !EX_Stall && !EX_Flush && (op_mul || op_div || op_mt);
   end

   always_comb begin
      ext_a    = {{32{op_signed & EX_OpA[31]}}, EX_OpA};
      ext_b    = {{32{op_signed & EX_OpB[31]}}, EX_OpB};
      product  = ext_a * ext_b;
      abs_a    = (op_signed && EX_OpA[31]) ? -EX_OpA : EX_OpA;
      abs_b    = (op_signed && EX_OpB[31]) ? -EX_OpB : EX_OpB;
      div_zero = (EX_OpB == 32'd0);
      rem_sh   = {acc_q[63:32], acc_q[31]};
      trial    = {1'b0, rem_sh} - {2'b00, dvs_q};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MULDIV_MADD_EN
      mode_d  = mode_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (EX_MulDivOp == 4'd9) hi_d = EX_OpA;
               if (EX_MulDivOp == 4'd10) lo_d = EX_OpA;
               if (op_mul) begin
                  state_d = StMul;
                  cnt_d   = 5'(MUL_CYCLES - 1);
                  acc_d   = product;
`ifdef MULDIV_MADD_EN
                  mode_d  = op_mode;
`endif
               end
               if (op_div) begin
                  state_d = StDiv;
                  cnt_d   = 5'd31;
                  acc_d   = {32'd0, abs_a};
                  dvs_d   = abs_b;
                  // Zero divisor suppresses sign fixup so LO stays all-ones
                  qneg_d  = op_signed & (EX_OpA[31] ^ EX_OpB[31]) & !div_zero;
                  rneg_d  = op_signed & EX_OpA[31] & !div_zero;
               end
            end
         end
         StMul: begin
            if (EX_Flush) begin
               state_d = StIdle;
            end else if (cnt_q == 5'd0) begin
               state_d = StIdle;
`ifdef MULDIV_MADD_EN
               case (mode_q)
                  2'd1:    {hi_d, lo_d} = {hi_q, lo_q} + acc_q;
                  2'd2:    {hi_d, lo_d} = {hi_q, lo_q} - acc_q;
                  default: {hi_d, lo_d} = acc_q;
               endcase
`else
               {hi_d, lo_d} = acc_q;
`endif
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         StDiv: begin
            if (EX_Flush) begin
               state_d = StIdle;
            end else begin
               if (!trial[33]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
               else            acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
               if (cnt_q == 5'd0) state_d = StFix;
               else               cnt_d   = cnt_q - 5'd1;
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!EX_Flush) begin
               lo_d = qneg_q ? -acc_q[31:0] : acc_q[31:0];
               hi_d = rneg_q ? -acc_q[63:32] : acc_q[63:32];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 5'd0;
         acc_q   <= 64'd0;
         dvs_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
`ifdef MULDIV_MADD_EN
         mode_q  <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MULDIV_MADD_EN
         mode_q  <= mode_d;
`endif
      end
   end

   assign MD_Busy  = (state_q != StIdle);
   assign MD_Stall = op_any && MD_Busy;
   assign MD_Hi    = hi_q;
   assign MD_Lo    = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit (MUL_CYCLES = 2).
module tb_mips_muldiv_unit;
   localparam int unsigned MC = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        EX_Stall = 1'b0;
   logic        EX_Flush = 1'b0;
   logic [3:0]  EX_MulDivOp = 4'd0;
   logic [31:0] EX_OpA = 32'd0;
   logic [31:0] EX_OpB = 32'd0;
   logic        MD_Busy, MD_Stall;
   logic [31:0] MD_Hi, MD_Lo;

   int vectors = 0;
   int miscompares = 0;
   int n;

   mips_muldiv_unit #(.MUL_CYCLES(MC)) dut (
      .clock(clock), .reset(reset), .EX_Stall(EX_Stall), .EX_Flush(EX_Flush),
      .EX_MulDivOp(EX_MulDivOp), .EX_OpA(EX_OpA), .EX_OpB(EX_OpB),
      .MD_Busy(MD_Busy), .MD_Stall(MD_Stall), .MD_Hi(MD_Hi), .MD_Lo(MD_Lo)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present an op for one cycle, then scramble operands to prove they were latched
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      EX_MulDivOp = op; EX_OpA = a; EX_OpB = b;
      @(negedge clock);
      EX_MulDivOp = 4'd0; EX_OpA = 32'hDEADBEEF; EX_OpB = 32'h0BADF00D;
   endtask

   task automatic run(output int cyc);
      cyc = 0;
      while (MD_Busy && cyc < 100) begin
         cyc++;
         @(negedge clock);
      end
   endtask

   initial begin
      @(negedge clock);
      check("reset_busy", 32'(MD_Busy), 32'd0);
      check("reset_hi", MD_Hi, 32'd0);
      check("reset_lo", MD_Lo, 32'd0);
      reset = 1'b0;

      issue(4'd1, 32'hFFFFFFFD, 32'd5);
      run(n);
      check("mult_busy_cycles", 32'(n), 32'(MC));
      check("mult_hi", MD_Hi, 32'hFFFFFFFF);
      check("mult_lo", MD_Lo, 32'hFFFFFFF1);

      issue(4'd4, 32'd100, 32'd7);
      run(n);
      check("divu_busy_cycles", 32'(n), 32'd33);
      check("divu_lo", MD_Lo, 32'd14);
      check("divu_hi", MD_Hi, 32'd2);

      issue(4'd3, 32'hFFFFFFF9, 32'd2);
      run(n);
      check("div_neg_lo", MD_Lo, 32'hFFFFFFFD);
      check("div_neg_hi", MD_Hi, 32'hFFFFFFFF);

      issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
      run(n);
      check("div_ovf_lo", MD_Lo, 32'h80000000);
      check("div_ovf_hi", MD_Hi, 32'd0);

      issue(4'd4, 32'h00001234, 32'd0);
      run(n);
      check("divz_lo", MD_Lo, 32'hFFFFFFFF);
      check("divz_hi", MD_Hi, 32'h00001234);

      // Flush a signed divide during iteration 10
      issue(4'd3, 32'd64, 32'd3);
      repeat (9) @(negedge clock);
      check("flush_busy_before", 32'(MD_Busy), 32'd1);
      EX_Flush = 1'b1;
      @(negedge clock);
      EX_Flush = 1'b0;
      check("flush_busy_after", 32'(MD_Busy), 32'd0);
      repeat (3) @(negedge clock);
      check("flush_hi_kept", MD_Hi, 32'h00001234);
      check("flush_lo_kept", MD_Lo, 32'hFFFFFFFF);

      // EX_Stall holds off acceptance
      @(negedge clock);
      EX_Stall = 1'b1; EX_MulDivOp = 4'd2; EX_OpA = 32'd7; EX_OpB = 32'd6;
      @(negedge clock);
      check("stall_no_accept", 32'(MD_Busy), 32'd0);
      EX_Stall = 1'b0;
      @(negedge clock);
      EX_MulDivOp = 4'd0;
      check("stall_then_accept", 32'(MD_Busy), 32'd1);
      run(n);
      check("multu_lo", MD_Lo, 32'd42);
      check("multu_hi", MD_Hi, 32'd0);

      // MFLO waiting on a divide
      issue(4'd4, 32'd1000, 32'd3);
      @(negedge clock);
      EX_MulDivOp = 4'd12;
      #1;
      n = 0;
      while (MD_Stall && n < 100) begin
         n++;
         @(negedge clock);
         #1;
      end
      check("mflo_stall_cycles", 32'(n), 32'd32);
      check("mflo_lo", MD_Lo, 32'd333);
      check("mflo_hi", MD_Hi, 32'd1);
      EX_MulDivOp = 4'd0;

      // Flush in IDLE blocks MTLO
      @(negedge clock);
      EX_MulDivOp = 4'd10; EX_OpA = 32'd55; EX_Flush = 1'b1;
      @(negedge clock);
      EX_MulDivOp = 4'd0; EX_Flush = 1'b0;
      check("idle_flush_blocks", MD_Lo, 32'd333);

      issue(4'd10, 32'h10, 32'd0);
      issue(4'd9, 32'd0, 32'd0);
      issue(4'd5, 32'd3, 32'd4);
`ifdef MULDIV_MADD_EN
      run(n);
      check("madd_hi", MD_Hi, 32'd0);
      check("madd_lo", MD_Lo, 32'h1C);
`else
      check("madd_off_busy", 32'(MD_Busy), 32'd0);
      run(n);
      check("madd_off_hi", MD_Hi, 32'd0);
      check("madd_off_lo", MD_Lo, 32'h10);
`endif
      issue(4'd10, 32'h10, 32'd0);
      issue(4'd9, 32'd0, 32'd0);
      issue(4'd7, 32'd3, 32'd4);
`ifdef MULDIV_MADD_EN
      run(n);
      check("msub_hi", MD_Hi, 32'd0);
      check("msub_lo", MD_Lo, 32'h4);
`else
      check("msub_off_busy", 32'(MD_Busy), 32'd0);
      run(n);
      check("msub_off_lo", MD_Lo, 32'h10);
`endif

      // Asynchronous reset in the middle of a multiply
      issue(4'd1, 32'd3, 32'd3);
      check("mul_busy_pre_reset", 32'(MD_Busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_reset_hi", MD_Hi, 32'd0);
      check("async_reset_lo", MD_Lo, 32'd0);
      check("async_reset_busy", 32'(MD_Busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
